// File: rtl/traffic_light_monitor_if.sv
// Observation port of the traffic light monitor: the light bus and error clear
// come in, decoded phase, error status and timing statistics go out.
interface traffic_light_monitor_if;
   logic [2:0]  light_in;
   logic        err_clr;
   logic [1:0]  phase;
   logic        phase_valid;
   logic        code_err;
   logic        seq_err;
   logic        dur_err;
   logic        err_pulse;
   logic [7:0]  last_dur;
   logic [15:0] cycle_count;

   modport master (
      output light_in, err_clr,
      input  phase, phase_valid, code_err, seq_err, dur_err, err_pulse,
             last_dur, cycle_count
   );

   modport slave (
      input  light_in, err_clr,
      output phase, phase_valid, code_err, seq_err, dur_err, err_pulse,
             last_dur, cycle_count
   );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for the {RED,YELLOW,GREEN} light bus: decodes the phase, times
// each phase, and flags illegal codes, out-of-order phases and bad durations.
module traffic_light_monitor #(
   parameter int GREEN_TIME  = 25,
   parameter int YELLOW_TIME = 4,
   parameter int RED_TIME    = 30,
   parameter int TOL         = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   traffic_light_monitor_if.slave  mon
);

   typedef enum logic [1:0] {SYNC, GREEN, YELLOW, RED} state_t;

   localparam logic [2:0] CODE_G = 3'b001;
   localparam logic [2:0] CODE_Y = 3'b010;
   localparam logic [2:0] CODE_R = 3'b100;
   localparam logic [1:0] PH_G   = 2'b00;
   localparam logic [1:0] PH_Y   = 2'b01;
   localparam logic [1:0] PH_R   = 2'b10;

   state_t      state, state_nxt, new_st;
   logic        measured, measured_nxt;
   logic [2:0]  light_q;
   logic [7:0]  dur_cnt;
   logic        change;
   logic        code_ev, seq_ev, dur_ev, count_ev, load_dur;
   logic        code_err, seq_err, dur_err, err_pulse;
   logic [7:0]  last_dur;
   logic [15:0] cycle_count;

   function automatic state_t code_state(input logic [2:0] c);
      case (c)
         CODE_G:  return GREEN;
         CODE_Y:  return YELLOW;
         CODE_R:  return RED;
         default: return SYNC;
      endcase
   endfunction

   function automatic state_t succ(input state_t s);
      case (s)
         GREEN:   return YELLOW;
         YELLOW:  return RED;
         RED:     return GREEN;
         default: return SYNC;
      endcase
   endfunction

   function automatic int exp_len(input state_t s);
      case (s)
         GREEN:   return GREEN_TIME + 1;
         YELLOW:  return YELLOW_TIME + 1;
         RED:     return RED_TIME + 1;
         default: return 0;
      endcase
   endfunction

   // A saturated count stays at 255 and therefore fails any realistic window.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic dur_ok(input logic [7:0] d, input int exp_t);
      return (int'(d) >= exp_t - TOL) && (int'(d) <= exp_t + TOL);
   endfunction

   always_comb begin
      change       = (mon.light_in != light_q);
      new_st       = code_state(mon.light_in);
      state_nxt    = state;
      measured_nxt = measured;
      code_ev      = 1'b0;
      seq_ev       = 1'b0;
      dur_ev       = 1'b0;
      count_ev     = 1'b0;
      load_dur     = 1'b0;
      if (change) begin
         if (new_st == SYNC) begin
            // Only the step from a legal code into an illegal one is an event.
            code_ev      = (code_state(light_q) != SYNC);
            state_nxt    = SYNC;
            measured_nxt = 1'b0;
         end else if (state == SYNC) begin
            state_nxt    = new_st;
            measured_nxt = 1'b0;
         end else if (new_st == succ(state)) begin
            state_nxt    = new_st;
            measured_nxt = 1'b1;
            load_dur     = 1'b1;
            dur_ev       = measured && !dur_ok(dur_cnt, exp_len(state));
            count_ev     = measured && (state == RED);
         end else begin
            state_nxt    = new_st;
            measured_nxt = 1'b0;
            load_dur     = 1'b1;
            seq_ev       = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= SYNC;
         measured    <= 1'b0;
         light_q     <= 3'b000;
         dur_cnt     <= 8'd0;
         code_err    <= 1'b0;
         seq_err     <= 1'b0;
         dur_err     <= 1'b0;
         err_pulse   <= 1'b0;
         last_dur    <= 8'd0;
         cycle_count <= 16'd0;
      end else begin
         state     <= state_nxt;
         measured  <= measured_nxt;
         light_q   <= mon.light_in;
         dur_cnt   <= change ? 8'd1 : sat_inc(dur_cnt);
         // A new event on the clearing edge wins over the clear.
         code_err  <= (code_err & ~mon.err_clr) | code_ev;
         seq_err   <= (seq_err  & ~mon.err_clr) | seq_ev;
         dur_err   <= (dur_err  & ~mon.err_clr) | dur_ev;
         err_pulse <= code_ev | seq_ev | dur_ev;
         if (load_dur) last_dur <= dur_cnt;
         if (count_ev) cycle_count <= cycle_count + 16'd1;
      end
   end

   always_comb begin
      case (state)
         YELLOW:  mon.phase = PH_Y;
         RED:     mon.phase = PH_R;
         default: mon.phase = PH_G;
      endcase
   end

   assign mon.phase_valid = (state != SYNC);
   assign mon.code_err    = code_err;
   assign mon.seq_err     = seq_err;
   assign mon.dur_err     = dur_err;
   assign mon.err_pulse   = err_pulse;
   assign mon.last_dur    = last_dur;
   assign mon.cycle_count = cycle_count;

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker that sits on the 3-bit `{RED,YELLOW,GREEN}` light bus driven by the traffic light controller. It decodes the bus into a phase and measures how long each phase lasts. It checks the phase order G→Y→R→G and each phase length against the controller's timing parameters. It reports sticky error flags, a one-cycle error pulse, the last measured duration, and a count of completed light cycles for the bench or the board status LEDs.

## Interface
- `GREEN_TIME`, default 25: controller green parameter; expected green duration = GREEN_TIME+1 cycles.
- `YELLOW_TIME`, default 4: expected yellow duration = YELLOW_TIME+1 cycles.
- `RED_TIME`, default 30: expected red duration = RED_TIME+1 cycles.
- `TOL`, default 0: allowed ± deviation in cycles on every duration check.
- `clk`  input  1  clock.
- `reset`  input  1  asynchronous, active-high.
- `light_in`  input  3  observed bus: bit2 RED, bit1 YELLOW, bit0 GREEN; synchronous to clk.
- `err_clr`  input  1  synchronous clear of sticky error flags.
- `phase`  output  2  decoded phase: 00 GREEN, 01 YELLOW, 10 RED.
- `phase_valid`  output  1  high while tracking a legal phase.
- `code_err`  output  1  sticky; a non-one-hot code was sampled.
- `seq_err`  output  1  sticky; a legal code appeared out of order.
- `dur_err`  output  1  sticky; a measured phase length was outside expected ±TOL.
- `err_pulse`  output  1  one-cycle pulse for any new error event.
- `last_dur`  output  8  duration in cycles of the most recently completed phase.
- `cycle_count`  output  16  completed R→G transitions; wraps at 65535→0.

## Operation
- Sample register `light_q` captures `light_in` on every edge. A change is detected at an edge when `light_in != light_q`.
- Duration counter `dur_cnt` (8 bit):
  - Loads 1 on the edge that captures a new code.
  - Increments on each edge with no change.
  - Saturates at 255.
  - At a change, `dur_cnt` equals the number of edges the old code was held.
- FSM states are SYNC, GREEN, YELLOW, RED. A `measured` flag marks phases that were entered through a legal transition.
- **SYNC** (reset state): the first legal one-hot code moves the FSM to the matching state with `measured`=0. `phase_valid`=1 from that point.
- **Legal transition** (G→Y, Y→R or R→G at a change):
  - Move to the next state and set `measured`=1.
  - `last_dur` ← `dur_cnt`.
  - If the outgoing phase had `measured`=1 and `dur_cnt` is outside [EXP−TOL, EXP+TOL], set `dur_err`.
  - R→G also increments `cycle_count`.
- **Out-of-order legal code** (G→R, Y→G, R→Y): set `seq_err`, load `last_dur`, skip the duration check, move to the state of the new code with `measured`=0.
- **Illegal code** (000, 011, 101, 110, 111) sampled in any state: set `code_err`, go to SYNC, `phase_valid`=0. `last_dur` and `cycle_count` hold.
- **Repeated illegal codes**: flag only on entry to the illegal code. A change between two different illegal codes raises no new pulse.
- **Saturated duration**: `dur_cnt` at 255 compares as 255, so an overly long phase always fails.
- **`err_pulse`**: high for exactly one cycle per edge on which at least one error event occurs.
- **`err_clr`**: clears all three sticky flags. If an error event occurs on the same edge, that flag ends set.

## Timing
- Reset values: `phase`=00, `phase_valid`=0, all errors 0, `err_pulse`=0, `last_dur`=0, `cycle_count`=0. Internally: state SYNC, `light_q`=000, `dur_cnt`=0.
- Reset is honoured mid-phase: everything returns to reset values and tracking restarts in SYNC.
- Latency:
  - `phase`, `phase_valid`, error flags, `err_pulse`, `last_dur` and `cycle_count` all update on the edge that captures the changed code into `light_q`. They are visible one cycle after `light_in` changes.
  - After reset release, the first captured legal code asserts `phase_valid` on the first edge. Because of the SYNC rule, that phase is never duration-checked.
- No handshake; the monitor never back-pressures the bus.

## Test plan
- **Nominal loop**: reset, then green 26, yellow 5, red 31 cycles, repeated 3 times → no errors. `last_dur` reads 26, 5, 31 in turn; `cycle_count`=3; first green unchecked.
- **Short yellow**: yellow held 3 cycles in the second loop with TOL=0 → `dur_err`=1 and a single `err_pulse` one cycle after the Y→R change; `last_dur`=3. With TOL=2, the same stimulus gives no error.
- **Sequence skip**: green 26 cycles, then red directly → `seq_err`=1, `phase`=10, `dur_err`=0. A following R→G leaves `cycle_count` unchanged, because the red phase is unmeasured and counting follows the R→G rule.
- **Illegal code**: 011 for 2 cycles during red → `code_err`=1 with one pulse, `phase_valid`=0. Then 001 → `phase_valid`=1, phase GREEN; that green is not duration-checked.
- **Clear collision**: assert `err_clr` alone → all flags 0. Assert `err_clr` on the same edge as a G→R skip → `seq_err`=1, others 0.
- **Reset mid-red and saturation**: async reset mid-red → all outputs return to reset values immediately. Then green held 300 cycles followed by yellow → `last_dur`=255, `dur_err`=1.
